// File: rtl/tmr_pkg.sv
// Shared types and lane constants for the TMR voter controller.
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_PROBE    = 2'd2,
        ST_FATAL    = 2'd3
    } state_e;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE_A = 2'd0;
    localparam lane_t LANE_B = 2'd1;
    localparam lane_t LANE_C = 2'd2;

    function automatic logic [2:0] lane_onehot(input lane_t l);
        return 3'b001 << l;
    endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane consecutive-mismatch counter; saturates at ERR_THRESH and flags it.
module tmr_lane_monitor #(
    parameter int ERR_THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic mismatch,
    input  logic clear,
    output logic tripped
);
    import tmr_pkg::*;

    localparam int CW = $clog2(ERR_THRESH + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (valid) begin
            if (!mismatch)
                count <= '0;
            else if (count != CW'(ERR_THRESH))
                count <= count + 1'b1;
        end
    end

    assign tripped = (count == CW'(ERR_THRESH));

endmodule

// File: rtl/tmr_voter_ctrl.sv
// TMR voter with lane fencing, resync handshake, probe-before-readmit and sticky fatal.
// Handshake: resync_req/resync_lane stay asserted while DEGRADED; one cycle of resync_ack completes it.
module tmr_voter_ctrl
    import tmr_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ERR_THRESH = 4,
    parameter int PROBE_LEN  = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [2:0]       lane_err,
    output logic [2:0]       fenced,
    output logic             resync_req,
    output logic [1:0]       resync_lane,
    input  logic             resync_ack,
    output logic             fatal,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int PW = $clog2(PROBE_LEN + 1);

    state_e          state;
    lane_t           fen_idx;
    logic [PW-1:0]   probe_cnt;
    logic [WIDTH-1:0] maj, sv, s1w, fw;
    lane_t           s0, s1, trip_idx;
    logic            surv_diff, fen_bad, probe_done, clear_all, mon_valid;
    logic [2:0]      err, tripped;
    logic            trip_any, trip_many;

    function automatic logic [WIDTH-1:0] pick(input lane_t l, input logic [WIDTH-1:0] wa,
                                              input logic [WIDTH-1:0] wb, input logic [WIDTH-1:0] wc);
        case (l)
            LANE_A:  return wa;
            LANE_B:  return wb;
            default: return wc;
        endcase
    endfunction

    always_comb begin
        maj       = (a & b) | (a & c) | (b & c);
        // Survivors are the two unfenced lanes, s0 being the lower index.
        s0        = (fen_idx == LANE_A) ? LANE_B : LANE_A;
        s1        = (fen_idx == LANE_C) ? LANE_B : LANE_C;
        sv        = pick(s0, a, b, c);
        s1w       = pick(s1, a, b, c);
        fw        = pick(fen_idx, a, b, c);
        surv_diff = (sv != s1w);
        fen_bad   = (fw != sv);
        err       = '0;
        if (state == ST_NORMAL) begin
            err = {c != maj, b != maj, a != maj};
        end else if (state == ST_DEGRADED || state == ST_PROBE) begin
            if (surv_diff) err = lane_onehot(s0) | lane_onehot(s1);
            if (fen_bad)   err = err | lane_onehot(fen_idx);
        end
    end

    assign trip_any   = |tripped;
    assign trip_many  = (tripped[0] & tripped[1]) | (tripped[0] & tripped[2]) | (tripped[1] & tripped[2]);
    assign trip_idx   = tripped[0] ? LANE_A : (tripped[1] ? LANE_B : LANE_C);
    assign probe_done = (probe_cnt == PW'(PROBE_LEN - 1));
    assign clear_all  = (state == ST_PROBE) && valid_in && !surv_diff && !fen_bad && probe_done;
    assign mon_valid  = valid_in && (state != ST_FATAL);

    for (genvar i = 0; i < 3; i++) begin : g_mon
        tmr_lane_monitor #(.ERR_THRESH(ERR_THRESH)) u_mon (
            .clk      (clk),
            .rst      (rst),
            .valid    (mon_valid),
            .mismatch (err[i]),
            .clear    (clear_all),
            .tripped  (tripped[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_NORMAL;
            fen_idx      <= LANE_A;
            probe_cnt    <= '0;
            y            <= '0;
            y_valid      <= 1'b0;
            lane_err     <= '0;
            mismatch_cnt <= '0;
        end else begin
            y_valid  <= 1'b0;
            lane_err <= '0;
            if (mon_valid) begin
                lane_err <= err;
                if (|err && mismatch_cnt != '1)
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                if (state == ST_NORMAL) begin
                    y       <= maj;
                    y_valid <= 1'b1;
                end else if (!surv_diff) begin
                    y       <= sv;
                    y_valid <= 1'b1;
                end
            end
            case (state)
                ST_NORMAL: begin
                    if (trip_many) begin
                        state <= ST_FATAL;
                    end else if (trip_any) begin
                        state   <= ST_DEGRADED;
                        fen_idx <= trip_idx;
                    end
                end
                ST_DEGRADED: begin
                    if (valid_in && surv_diff) begin
                        state <= ST_FATAL;
                    end else if (resync_ack) begin
                        state     <= ST_PROBE;
                        probe_cnt <= '0;
                    end
                end
                ST_PROBE: begin
                    if (valid_in) begin
                        if (surv_diff) begin
                            state <= ST_FATAL;
                        end else if (fen_bad) begin
                            state     <= ST_DEGRADED;
                            probe_cnt <= '0;
                        end else if (probe_done) begin
                            state     <= ST_NORMAL;
                            probe_cnt <= '0;
                        end else begin
                            probe_cnt <= probe_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fenced      = (state == ST_DEGRADED || state == ST_PROBE) ? lane_onehot(fen_idx) : 3'b000;
    assign resync_req  = (state == ST_DEGRADED);
    assign resync_lane = fen_idx;
    assign fatal       = (state == ST_FATAL);

endmodule

// File: tb/tb_tmr_voter_ctrl.sv
// Self-checking bench for tmr_voter_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_tmr_voter_ctrl;

    localparam int WIDTH      = 8;
    localparam int ERR_THRESH = 4;
    localparam int PROBE_LEN  = 16;
    localparam int CNT_W      = 8;

    localparam int M_OK   = 0;
    localparam int M_DEG  = 1;
    localparam int M_PRB  = 2;
    localparam int M_DEAD = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0, c = '0;
    logic             resync_ack = 1'b0;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [2:0]       lane_err, fenced;
    logic             resync_req, fatal;
    logic [1:0]       resync_lane;
    logic [CNT_W-1:0] mismatch_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // reference model state
    int         m_mode = M_OK;
    int         m_fen = -1;
    int         m_cnt[3] = '{0, 0, 0};
    int         m_probe = 0;
    int         m_mcnt = 0;
    logic [7:0] m_y = '0;
    logic       m_yv = 1'b0;
    logic [2:0] m_err = '0;

    tmr_voter_ctrl #(
        .WIDTH(WIDTH), .ERR_THRESH(ERR_THRESH), .PROBE_LEN(PROBE_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .a(a), .b(b), .c(c),
        .y(y), .y_valid(y_valid), .lane_err(lane_err), .fenced(fenced),
        .resync_req(resync_req), .resync_lane(resync_lane), .resync_ack(resync_ack),
        .fatal(fatal), .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: advanced on every rising edge from the inputs held across it.
    always @(posedge clk) begin : model
        logic [7:0] w[3];
        logic [7:0] maj, sv;
        logic [2:0] errs;
        int ntrip, tlane, s0, s1, ones, prev;
        bit clear_all;
        if (rst) begin
            m_mode = M_OK; m_fen = -1; m_probe = 0; m_mcnt = 0;
            m_y = '0; m_yv = 1'b0; m_err = '0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            w[0] = a; w[1] = b; w[2] = c;
            errs = '0; clear_all = 0; ntrip = 0; tlane = 0; prev = m_mode;
            for (int i = 2; i >= 0; i--) if (m_cnt[i] == ERR_THRESH) begin ntrip++; tlane = i; end
            m_yv = 1'b0;
            if (prev == M_OK) begin
                if (valid_in) begin
                    for (int k = 0; k < 8; k++) begin
                        ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
                        maj[k] = (ones >= 2);
                    end
                    for (int i = 0; i < 3; i++) errs[i] = (w[i] != maj);
                    m_y = maj; m_yv = 1'b1;
                end
                if (ntrip >= 2) m_mode = M_DEAD;
                else if (ntrip == 1) begin m_mode = M_DEG; m_fen = tlane; end
            end else if (prev == M_DEG || prev == M_PRB) begin
                s0 = (m_fen == 0) ? 1 : 0;
                s1 = (m_fen == 2) ? 1 : 2;
                sv = w[s0];
                if (valid_in) begin
                    if (w[m_fen] != sv) errs[m_fen] = 1'b1;
                    if (w[s1] != sv) begin
                        errs[s0] = 1'b1; errs[s1] = 1'b1; m_mode = M_DEAD;
                    end else begin
                        m_y = sv; m_yv = 1'b1;
                        if (prev == M_PRB) begin
                            if (errs[m_fen]) begin m_probe = 0; m_mode = M_DEG; end
                            else begin
                                m_probe++;
                                if (m_probe == PROBE_LEN) begin
                                    m_probe = 0; m_mode = M_OK; m_fen = -1; clear_all = 1;
                                end
                            end
                        end
                    end
                end
                if (prev == M_DEG && m_mode == M_DEG && resync_ack) begin m_mode = M_PRB; m_probe = 0; end
            end
            if (valid_in && prev != M_DEAD) begin
                for (int i = 0; i < 3; i++) m_cnt[i] = errs[i] ? ((m_cnt[i] < ERR_THRESH) ? m_cnt[i] + 1 : m_cnt[i]) : 0;
                if (errs != 0 && m_mcnt < 255) m_mcnt++;
                m_err = errs;
            end else begin
                m_err = '0;
            end
            if (clear_all) for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end
    end

    // Scoreboard: every output against the model, away from the active edge.
    always @(negedge clk) begin : scoreboard
        logic [2:0] e_fen;
        e_fen = (m_mode == M_DEG || m_mode == M_PRB) ? 3'(1 << m_fen) : 3'b000;
        if (chk_en) begin
            n_cmp++; if (y !== m_y) begin n_err++; $display("FAIL sb_y: got %h exp %h t=%0t", y, m_y, $time); end
            n_cmp++; if (y_valid !== m_yv) begin n_err++; $display("FAIL sb_y_valid: got %b exp %b t=%0t", y_valid, m_yv, $time); end
            n_cmp++; if (lane_err !== m_err) begin n_err++; $display("FAIL sb_lane_err: got %b exp %b t=%0t", lane_err, m_err, $time); end
            n_cmp++; if (fenced !== e_fen) begin n_err++; $display("FAIL sb_fenced: got %b exp %b t=%0t", fenced, e_fen, $time); end
            n_cmp++; if (resync_req !== (m_mode == M_DEG)) begin n_err++; $display("FAIL sb_resync_req: got %b exp %b t=%0t", resync_req, m_mode == M_DEG, $time); end
            if (m_mode == M_DEG) begin
                n_cmp++; if (resync_lane !== 2'(m_fen)) begin n_err++; $display("FAIL sb_resync_lane: got %0d exp %0d t=%0t", resync_lane, m_fen, $time); end
            end
            n_cmp++; if (fatal !== (m_mode == M_DEAD)) begin n_err++; $display("FAIL sb_fatal: got %b exp %b t=%0t", fatal, m_mode == M_DEAD, $time); end
            n_cmp++; if (mismatch_cnt !== 8'(m_mcnt)) begin n_err++; $display("FAIL sb_mismatch_cnt: got %0d exp %0d t=%0t", mismatch_cnt, m_mcnt, $time); end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic, input logic ack);
        rst = r; valid_in = v; a = ia; b = ib; c = ic; resync_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 8'h00, 8'h00, 8'h00, 0);
        chk_en = 1;
        n_cmp++; if ({y, y_valid, lane_err, fenced, resync_req, resync_lane, fatal, mismatch_cnt} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got y=%h yv=%b err=%b fen=%b req=%b lane=%0d fatal=%b cnt=%0d exp all 0",
                              y, y_valid, lane_err, fenced, resync_req, resync_lane, fatal, mismatch_cnt);
        end
    endtask

    task automatic test_unanimous;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 8'h5A, 8'h5A, 8'h5A, 0);
            n_cmp++; if (y !== 8'h5A || y_valid !== 1'b1) begin n_err++; $display("FAIL unanimous_y: got %h/%b exp 5a/1", y, y_valid); end
            n_cmp++; if (lane_err !== 3'b000 || fenced !== 3'b000 || mismatch_cnt !== 8'd0) begin
                n_err++; $display("FAIL unanimous_flags: got err=%b fen=%b cnt=%0d exp 0/0/0", lane_err, fenced, mismatch_cnt);
            end
        end
    endtask

    task automatic test_vote_combos;
        logic [7:0] wa, wb, wc, e_y;
        int ones, nerr;
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            wa = k[0] ? 8'hFF : 8'h00; wb = k[1] ? 8'hFF : 8'h00; wc = k[2] ? 8'hFF : 8'h00;
            ones = int'(k[0]) + int'(k[1]) + int'(k[2]);
            e_y  = (ones >= 2) ? 8'hFF : 8'h00;
            nerr = (ones == 0 || ones == 3) ? 0 : 1;
            drive(0, 1, wa, wb, wc, 0);
            n_cmp++; if (y !== e_y) begin n_err++; $display("FAIL combo_y[%0d]: got %h exp %h", k, y, e_y); end
            n_cmp++; if ($countones(lane_err) != nerr) begin n_err++; $display("FAIL combo_err[%0d]: got %b exp %0d bits", k, lane_err, nerr); end
        end
        n_cmp++; if (mismatch_cnt !== 8'd6) begin n_err++; $display("FAIL combo_cnt: got %0d exp 6", mismatch_cnt); end
    endtask

    task automatic fence_b;
        for (int i = 0; i < 4; i++) drive(0, 1, 8'h00, 8'h01, 8'h00, 0);
        drive(0, 0, 8'h00, 8'h00, 8'h00, 0);
    endtask

    task automatic test_fence;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 8'h00, 8'h01, 8'h00, 0);
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (fenced !== 3'b000) begin n_err++; $display("FAIL fence_early: got %b exp 000", fenced); end
        drive(0, 1, 8'h00, 8'h00, 8'h00, 0);
        fence_b();
        n_cmp++; if (fenced !== 3'b010) begin n_err++; $display("FAIL fence_set: got %b exp 010", fenced); end
        n_cmp++; if (resync_req !== 1'b1 || resync_lane !== 2'd1) begin
            n_err++; $display("FAIL fence_resync: got req=%b lane=%0d exp 1/1", resync_req, resync_lane);
        end
    endtask

    task automatic test_probe;
        logic [7:0] w;
        drive(0, 0, 0, 0, 0, 1);
        n_cmp++; if (resync_req !== 1'b0 || fenced !== 3'b010) begin
            n_err++; $display("FAIL probe_enter: got req=%b fen=%b exp 0/010", resync_req, fenced);
        end
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom);
            drive(0, 1, w, w, w, 0);
        end
        n_cmp++; if (fenced !== 3'b000 || resync_req !== 1'b0 || fatal !== 1'b0) begin
            n_err++; $display("FAIL probe_readmit: got fen=%b req=%b fatal=%b exp 000/0/0", fenced, resync_req, fatal);
        end
        fence_b();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            w = 8'($urandom);
            drive(0, 1, w, (i == 10) ? ~w : w, w, 0);
        end
        n_cmp++; if (resync_req !== 1'b1 || fenced !== 3'b010) begin
            n_err++; $display("FAIL probe_fail: got req=%b fen=%b exp 1/010", resync_req, fenced);
        end
    endtask

    task automatic test_fatal;
        logic [7:0] y_hold;
        y_hold = y;
        drive(0, 1, 8'h10, 8'h10, 8'h20, 0);
        n_cmp++; if (fatal !== 1'b1 || y_valid !== 1'b0 || y !== y_hold) begin
            n_err++; $display("FAIL fatal_enter: got fatal=%b yv=%b y=%h exp 1/0/%h", fatal, y_valid, y, y_hold);
        end
        for (int i = 0; i < 4; i++) drive(0, 1, 8'($urandom), 8'($urandom), 8'($urandom), 1);
        n_cmp++; if (fatal !== 1'b1 || resync_req !== 1'b0 || y !== y_hold) begin
            n_err++; $display("FAIL fatal_sticky: got fatal=%b req=%b y=%h exp 1/0/%h", fatal, resync_req, y, y_hold);
        end
        drive(1, 0, 0, 0, 0, 0);
        n_cmp++; if ({y, y_valid, lane_err, fenced, resync_req, fatal, mismatch_cnt} !== '0) begin
            n_err++; $display("FAIL fatal_reset: got y=%h fen=%b fatal=%b cnt=%0d exp all 0", y, fenced, fatal, mismatch_cnt);
        end
    endtask

    task automatic test_double_trip;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) drive(0, 1, 8'h00, 8'h01, 8'h02, 0);
        for (int i = 0; i < 2; i++) drive(0, 0, 8'h00, 8'h01, 8'h02, 0);
        n_cmp++; if (fatal !== 1'b0) begin n_err++; $display("FAIL double_gap: got fatal=%b exp 0", fatal); end
        for (int i = 0; i < 2; i++) drive(0, 1, 8'h00, 8'h01, 8'h02, 0);
        n_cmp++; if (fatal !== 1'b0 || y !== 8'h00 || lane_err !== 3'b110) begin
            n_err++; $display("FAIL double_pre: got fatal=%b y=%h err=%b exp 0/00/110", fatal, y, lane_err);
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (fatal !== 1'b1 || fenced !== 3'b000) begin
            n_err++; $display("FAIL double_fatal: got fatal=%b fen=%b exp 1/000", fatal, fenced);
        end
    endtask

    task automatic test_random;
        logic [7:0] base, w[3];
        int bad;
        drive(1, 0, 0, 0, 0, 0);
        bad = 3;
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) bad = $urandom_range(0, 3);
            base = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                w[i] = base;
                if ((i == bad && $urandom_range(0, 99) < 70) || $urandom_range(0, 99) < 3)
                    w[i] = base ^ 8'(1 << $urandom_range(0, 7));
            end
            drive((m_mode == M_DEAD && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 85, w[0], w[1], w[2], $urandom_range(0, 99) < 15);
        end
    endtask

    initial begin
        test_reset();
        test_unanimous();
        test_vote_combos();
        test_fence();
        test_probe();
        test_fatal();
        test_double_trip();
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tmr_voter_ctrl.md
Name: tmr_voter_ctrl

Overview:
Supervisory controller for a WIDTH-bit triple-modular-redundant (TMR) channel. Each cycle it votes the three replica words and registers the result. It tracks per-lane disagreement and fences a persistently faulty lane. It runs a resync handshake with the replica owner, probes the fenced lane before readmitting it, and escalates to a sticky fatal state when redundancy is lost. It sits between the three replica datapaths and the downstream consumer.

Parameters:
WIDTH, 8, width of each replica word and of y
ERR_THRESH, 4, consecutive valid mismatch cycles before a lane is fenced (≥1)
PROBE_LEN, 16, consecutive clean valid cycles required in PROBE before readmit (≥1)
CNT_W, 8, width of the saturating mismatch statistics counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
valid_in  in  1  a/b/c are sampled only when high
a  in  WIDTH  replica lane 0
b  in  WIDTH  replica lane 1
c  in  WIDTH  replica lane 2
y  out  WIDTH  voted/selected word, registered
y_valid  out  1  y updated this cycle
lane_err  out  3  registered per-lane disagreement flags, bit0=a
fenced  out  3  one-hot fenced lane, 0 when none
resync_req  out  1  request to resync the fenced lane
resync_lane  out  2  index of the lane to resync, valid with resync_req
resync_ack  in  1  owner acknowledges that resync is complete
fatal  out  1  sticky loss of redundancy
mismatch_cnt  out  CNT_W  saturating count of valid cycles with any lane_err bit set

Behaviour:
- Reset (rst=1 at clk edge): state=NORMAL. Outputs y=0, y_valid=0, lane_err=0, fenced=0, resync_req=0, resync_lane=0, fatal=0, mismatch_cnt=0. All lane and probe counters are 0. Reset overrides every state, including FATAL and mid-probe.
- Latency: 1 cycle. y, y_valid and lane_err reflect the inputs of the previous cycle. When valid_in=0: y holds, y_valid=0, lane_err=0, and all counters hold.
- Voting: v = bitwise majority (a&b | a&c | b&c). Lane x disagrees when x != v, word compare. More than one lane may disagree at once (e.g. a=00,b=01,c=10 gives v=00; lanes b and c disagree).
- Lane counter: on a valid cycle it increments while the lane disagrees and clears while it agrees. It saturates at ERR_THRESH.
- mismatch_cnt: +1 per valid cycle with any disagreement; saturates at all-ones.
- NORMAL: y=v.
  - Exactly one lane counter reaches ERR_THRESH: go to DEGRADED, set fenced to that lane.
  - Two or more reach ERR_THRESH on the same cycle: go to FATAL.
- DEGRADED: y = the lower-index surviving lane.
  - resync_req=1 with resync_lane = fenced index. Both are held until resync_ack is sampled high, then go to PROBE and drop resync_req.
  - Survivors differ on a valid cycle: go to FATAL.
- PROBE: y as in DEGRADED.
  - On each valid cycle where the fenced lane equals the surviving value, probe count +1.
  - On a fenced-lane mismatch, clear the probe count and return to DEGRADED, which re-raises resync_req.
  - When the count reaches PROBE_LEN: go to NORMAL, clear fenced, clear all lane counters.
  - Survivor disagreement has priority over probe fail and sends the FSM to FATAL.
- FATAL: fatal=1, y holds, y_valid=0, resync_req=0. Stays here until rst.
- lane_err in DEGRADED/PROBE: the fenced bit reports fenced-lane mismatch against the survivor value; survivor bits report survivor disagreement.
- resync_ack is ignored in every state except DEGRADED.

Decomposition:
- Package tmr_pkg:
  - state_e {ST_NORMAL, ST_DEGRADED, ST_PROBE, ST_FATAL}
  - lane_t (2-bit)
  - constants LANE_A=0, LANE_B=1, LANE_C=2
- Sub-module tmr_lane_monitor, instantiated 3×. It holds the consecutive-mismatch counter per lane:
  - inputs: clk, rst, valid, mismatch, clear
  - output: tripped (count==ERR_THRESH)

Test Plan:
1. Reset, then valid a=b=c=8'h5A for 8 cycles -> y=8'h5A one cycle after each input, lane_err=0, fenced=0, mismatch_cnt=0.
2. All 8 vote combinations of a,b,c ∈ {8'h00,8'hFF} -> y equals the majority word. Exactly one lane_err bit is set when lanes are split, none when unanimous. mismatch_cnt=6.
3. b=8'h01 with a=c=8'h00 for 3 valid cycles, one agree cycle, then 4 cycles -> no fence after the first 3. After the 4th consecutive mismatch: fenced=3'b010, resync_req=1, resync_lane=1.
4. From case 3, pulse resync_ack, then b=a=c for 16 valid cycles -> PROBE entered, resync_req=0. After the 16th clean cycle fenced=0 and the FSM is in NORMAL. Repeat, but mismatch b on cycle 10 -> back to DEGRADED, resync_req=1.
5. In DEGRADED with b fenced, drive a=8'h10, c=8'h20 -> fatal=1, y holds, y_valid=0. Driving further inputs or resync_ack does not clear it. rst=1 for one cycle clears all outputs to 0.
6. a=8'h00, b=8'h01, c=8'h02 for 4 valid cycles -> b and c trip together, FSM goes to FATAL, fenced stays 0. Deassert valid_in mid-sequence for 2 cycles -> counters hold, and the FATAL transition is delayed by exactly 2 cycles.
